// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: shared register offsets, FSM encoding and STATUS layout for int_ctrl
//   Exports OFS_* register offsets, state_e, STATUS field positions and vec_addr().
package int_ctrl_pkg;

    localparam logic [7:0] OFS_EN     = 8'd0;
    localparam logic [7:0] OFS_MASK   = 8'd1;
    localparam logic [7:0] OFS_PEND   = 8'd2;
    localparam logic [7:0] OFS_VBASE  = 8'd3;
    localparam logic [7:0] OFS_STATUS = 8'd4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    localparam int STATUS_STATE_LSB = 6;
    localparam int STATUS_ID_LSB    = 0;

    // Handler address, wrapping at 8 bits.
    function automatic logic [7:0] vec_addr(input logic [7:0] base, input logic [2:0] id,
                                            input logic [7:0] stride);
        return base + {5'b0, id} * stride;
    endfunction

endpackage

// File: rtl/int_ctrl_prio_enc.sv
// int_ctrl_prio_enc: combinational fixed-priority encoder, lowest index wins
//   cand_i  in  NUM_SRC  candidate requests (PENDING & MASK)
//   valid_o out 1        at least one candidate
//   id_o    out 3        index of the winning candidate (0 when none)
module int_ctrl_prio_enc #(
    parameter int unsigned NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0] cand_i,
    output logic               valid_o,
    output logic [2:0]         id_o
);

    // Scanning downward lets the lowest set index overwrite the rest.
    always_comb begin
        valid_o = 1'b0;
        id_o    = 3'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (cand_i[i]) begin
                valid_o = 1'b1;
                id_o    = 3'(i);
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: memory-mapped interrupt controller with fixed priority and EOI handshake
//   clock_i      in  1        system clock
//   reset_i      in  1        synchronous active-high reset
//   src_irq_i    in  NUM_SRC  peripheral requests
//   mem_addr_i   in  8        CPU bus address
//   mem_w_data_i in  8        CPU write data
//   mem_w_en_i   in  1        CPU write strobe
//   rd_data_o    out 8        register read data (0 when not hit)
//   hit_o        out 1        address inside BASE_ADDR..BASE_ADDR+4
//   int_req_o    out 1        one-cycle interrupt request pulse
//   int_en_o     out 8        EN register
//   int_vec_o    out 8        vector of the active source
// Optional build macro INT_CTRL_EDGE_DETECT_EN: capture on 0->1 edges instead of levels.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SRC    = 4,
    parameter logic [7:0]  BASE_ADDR  = 8'hF0,
    parameter int unsigned VEC_STRIDE = 4
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic [NUM_SRC-1:0] src_irq_i,
    input  logic [7:0]         mem_addr_i,
    input  logic [7:0]         mem_w_data_i,
    input  logic               mem_w_en_i,
    output logic [7:0]         rd_data_o,
    output logic               hit_o,
    output logic               int_req_o,
    output logic [7:0]         int_en_o,
    output logic [7:0]         int_vec_o
);

    state_e             state_q, state_d;
    logic [7:0]         en_q, vbase_q, vec_q;
    logic [NUM_SRC-1:0] mask_q, pend_q, pend_d;
    logic [2:0]         id_q;
    logic [NUM_SRC-1:0] cap_set, cap_clr;
    logic [7:0]         ofs, status;
    logic               wr_en, wr_mask, wr_pend, wr_vbase, eoi;
    logic               win_valid, issue;
    logic [2:0]         win_id;

    // Offset wraps at 8 bits, so the window is a simple unsigned compare.
    always_comb begin
        ofs      = mem_addr_i - BASE_ADDR;
        hit_o    = ofs <= OFS_STATUS;
        wr_en    = hit_o && mem_w_en_i && ofs == OFS_EN;
        wr_mask  = hit_o && mem_w_en_i && ofs == OFS_MASK;
        wr_pend  = hit_o && mem_w_en_i && ofs == OFS_PEND;
        wr_vbase = hit_o && mem_w_en_i && ofs == OFS_VBASE;
        eoi      = hit_o && mem_w_en_i && ofs == OFS_STATUS;
    end

    always_comb begin
        status    = ({6'b0, state_q} << STATUS_STATE_LSB) | ({5'b0, id_q} << STATUS_ID_LSB);
        rd_data_o = !hit_o              ? 8'h00 :
                    ofs == OFS_EN       ? en_q :
                    ofs == OFS_MASK     ? 8'(mask_q) :
                    ofs == OFS_PEND     ? 8'(pend_q) :
                    ofs == OFS_VBASE    ? vbase_q : status;
    end

`ifdef INT_CTRL_EDGE_DETECT_EN
    logic [NUM_SRC-1:0] prev_q;
    always_ff @(posedge clock_i) begin
        if (reset_i) prev_q <= '0;
        else         prev_q <= src_irq_i;
    end
    assign cap_set = src_irq_i & ~prev_q;
`else
    assign cap_set = src_irq_i;
`endif

    // Capture set is OR-ed last so it beats both the W1C and the REQ clear.
    always_comb begin
        cap_clr = (wr_pend ? mem_w_data_i[NUM_SRC-1:0] : '0) |
                  (state_q == ST_REQ ? NUM_SRC'(1) << id_q : '0);
        pend_d  = (pend_q & ~cap_clr) | cap_set;
    end

    int_ctrl_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio (
        .cand_i  (pend_q & mask_q),
        .valid_o (win_valid),
        .id_o    (win_id)
    );

    assign issue = state_q == ST_IDLE && en_q[0] && win_valid;

    always_ff @(posedge clock_i) begin
        if (reset_i) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q == ST_IDLE    ? (issue ? ST_REQ : ST_IDLE) :
                  state_q == ST_REQ     ? ST_SERVICE :
                  state_q == ST_SERVICE ? (eoi ? ST_IDLE : ST_SERVICE) : ST_IDLE;
    end

    always_comb begin
        int_req_o = state_q == ST_REQ;
        int_en_o  = en_q;
        int_vec_o = vec_q;
    end

    // Vector is frozen at issue so later MASK/VEC_BASE writes leave it alone.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            en_q    <= '0;
            mask_q  <= '0;
            pend_q  <= '0;
            vbase_q <= '0;
            id_q    <= '0;
            vec_q   <= '0;
        end else begin
            if (wr_en)    en_q    <= mem_w_data_i;
            if (wr_mask)  mask_q  <= mem_w_data_i[NUM_SRC-1:0];
            if (wr_vbase) vbase_q <= mem_w_data_i;
            pend_q <= pend_d;
            if (issue) begin
                id_q  <= win_id;
                vec_q <= vec_addr(vbase_q, win_id, 8'(VEC_STRIDE));
            end
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed and randomized checks of int_ctrl against a behavioural model
module tb_int_ctrl;

    localparam int         NUM_SRC = 4;
    localparam logic [7:0] BASE    = 8'hF0;
    localparam int         STRIDE  = 4;
`ifdef INT_CTRL_EDGE_DETECT_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_SRC-1:0] src;
    logic [7:0]         addr, wd;
    logic               we;
    logic [7:0]         rd, int_en, int_vec;
    logic               hit, int_req;

    always #10 clk = ~clk;

    int_ctrl #(.NUM_SRC(NUM_SRC), .BASE_ADDR(BASE), .VEC_STRIDE(STRIDE)) dut (
        .clock_i      (clk),
        .reset_i      (rst),
        .src_irq_i    (src),
        .mem_addr_i   (addr),
        .mem_w_data_i (wd),
        .mem_w_en_i   (we),
        .rd_data_o    (rd),
        .hit_o        (hit),
        .int_req_o    (int_req),
        .int_en_o     (int_en),
        .int_vec_o    (int_vec)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Model: phase 0 = waiting, 1 = request pulse, 2 = in service.
    logic [7:0]         m_en, m_vbase, m_vec;
    logic [NUM_SRC-1:0] m_mask, m_pend, m_prev;
    int                 m_phase, m_id;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_read(input logic [7:0] a);
        int o;
        o = int'(a) - int'(BASE);
        if (o < 0 || o > 4) return 8'h00;
        case (o)
            0:       return m_en;
            1:       return 8'(m_mask);
            2:       return 8'(m_pend);
            3:       return m_vbase;
            default: return {m_phase[1:0], 3'b000, m_id[2:0]};
        endcase
    endfunction

    task automatic model_edge();
        int o;
        logic [NUM_SRC-1:0] np;
        logic w;
        if (rst) begin
            m_en = 0; m_vbase = 0; m_vec = 0; m_mask = 0; m_pend = 0; m_prev = 0;
            m_phase = 0; m_id = 0;
            return;
        end
        o  = int'(addr) - int'(BASE);
        w  = we && o >= 0 && o <= 4;
        np = m_pend;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (m_phase == 1 && m_id == i) np[i] = 1'b0;
            if (w && o == 2 && wd[i]) np[i] = 1'b0;
            if (EDGE ? (src[i] && !m_prev[i]) : src[i]) np[i] = 1'b1;
        end
        m_prev = src;
        if (m_phase == 0) begin
            if (m_en[0]) begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (m_pend[i] && m_mask[i]) begin
                        m_id    = i;
                        m_vec   = 8'(int'(m_vbase) + i * STRIDE);
                        m_phase = 1;
                        break;
                    end
                end
            end
        end else if (m_phase == 1) m_phase = 2;
        else if (w && o == 4) m_phase = 0;
        if (w && o == 0) m_en = wd;
        if (w && o == 1) m_mask = wd[NUM_SRC-1:0];
        if (w && o == 3) m_vbase = wd;
        m_pend = np;
    endtask

    task automatic check_all();
        logic [7:0] probe [7] = '{8'hF0, 8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'hEF, 8'hF5};
        check("int_req", {7'b0, int_req}, {7'b0, m_phase == 1});
        check("int_vec", int_vec, m_vec);
        check("int_en", int_en, m_en);
        we = 1'b0;
        for (int i = 0; i < 7; i++) begin
            addr = probe[i];
            #1;
            check($sformatf("rd_%h", probe[i]), rd, m_read(probe[i]));
            check($sformatf("hit_%h", probe[i]), {7'b0, hit},
                  {7'b0, probe[i] >= BASE && probe[i] <= BASE + 8'd4});
        end
    endtask

    task automatic cyc(input logic r, input logic [NUM_SRC-1:0] s, input logic [7:0] a,
                       input logic [7:0] d, input logic w);
        rst = r; src = s; addr = a; wd = d; we = w;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic wr(input int o, input logic [7:0] d);
        cyc(1'b0, '0, 8'(int'(BASE) + o), d, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic rd_chk(input string tag, input int o, input logic [7:0] exp);
        we   = 1'b0;
        addr = 8'(int'(BASE) + o);
        #1;
        check(tag, rd, exp);
    endtask

    initial begin
        int  pulses;
        bit  done, eoi, r, w;
        int  o;
        logic [7:0] d;
        logic [NUM_SRC-1:0] s;

        cyc(1'b1, '0, 8'h00, 8'h00, 1'b0);
        cyc(1'b1, '0, 8'h00, 8'h00, 1'b0);
        check("reset_req", {7'b0, int_req}, 8'h00);
        check("reset_vec", int_vec, 8'h00);

        wr(0, 8'h01); wr(1, 8'h0F); wr(3, 8'h40);
        cyc(1'b0, 4'b0100, 8'h00, 8'h00, 1'b0);
        idle(1);
        check("t1_req", {7'b0, int_req}, 8'h01);
        check("t1_vec", int_vec, 8'h48);
        idle(1);
        check("t1_req_once", {7'b0, int_req}, 8'h00);
        rd_chk("t1_status", 4, 8'h82);
        rd_chk("t1_pend", 2, 8'h00);
        wr(4, 8'h00);

        cyc(1'b0, 4'b1010, 8'h00, 8'h00, 1'b0);
        idle(1);
        check("t2_vec1", int_vec, 8'h44);
        idle(1);
        wr(4, 8'h00);
        check("t2_gap", {7'b0, int_req}, 8'h00);
        idle(1);
        check("t2_req3", {7'b0, int_req}, 8'h01);
        check("t2_vec3", int_vec, 8'h4C);
        idle(1);

        cyc(1'b0, 4'b0001, 8'h00, 8'h00, 1'b0);
        idle(3);
        wr(4, 8'h00);
        idle(1);
        check("t3_vec0", int_vec, 8'h40);
        idle(1);
        wr(4, 8'h00);

        wr(1, 8'h00);
        cyc(1'b0, 4'b0010, 8'h00, 8'h00, 1'b0);
        idle(3);
        rd_chk("t4_pend_masked", 2, 8'h02);
        wr(1, 8'h02);
        idle(1);
        check("t4_unmask_req", {7'b0, int_req}, 8'h01);
        idle(1);
        cyc(1'b0, 4'b0010, 8'(int'(BASE) + 2), 8'h02, 1'b1);
        rd_chk("t4_set_beats_clr", 2, 8'h02);
        wr(4, 8'h00);
        idle(2);

        cyc(1'b1, '0, 8'h00, 8'h00, 1'b0);
        check("t5_rst_req", {7'b0, int_req}, 8'h00);
        check("t5_rst_vec", int_vec, 8'h00);
        rd_chk("t5_rst_status", 4, 8'h00);
        rd_chk("t5_rst_pend", 2, 8'h00);
        wr(4, 8'h00);
        rd_chk("t5_eoi_idle", 4, 8'h00);

        wr(0, 8'h01); wr(1, 8'h01);
        pulses = 0;
        done   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            eoi = m_phase == 2 && !done;
            cyc(1'b0, 4'b0001, eoi ? 8'(int'(BASE) + 4) : 8'h00, 8'h00, eoi);
            if (eoi) done = 1'b1;
            if (int_req === 1'b1) pulses++;
        end
        check("held_level_pulses", 8'(pulses), EDGE ? 8'd1 : 8'd2);
        wr(4, 8'h00);
        idle(2);

        wr(1, 8'h0F);
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 199) == 0;
            s = ($urandom_range(0, 3) == 0) ? NUM_SRC'($urandom) : '0;
            w = $urandom_range(0, 2) == 0;
            o = $urandom_range(0, 5);
            d = 8'($urandom);
            if (o == 0) d[0] = $urandom_range(0, 7) != 0;
            cyc(r, s, w ? 8'(int'(BASE) + o) : 8'($urandom), d, w);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
